fsm_fan_control: RTL and testbench
==================================

FSM_FAN_CONTROL -- requirements
Module: fsm_fan_control

Interface
REQ-001 Parameter ON_THRESHOLD, default 8'd20, temperature in °C at or above which the fan turns on.
REQ-002 Parameter OFF_THRESHOLD, default 8'd15, temperature in °C at or below which the fan turns off.
REQ-003 Parameter FILTER_CYCLES, default 16, consecutive qualifying samples required before a transition (range 1..65535).
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 temperature  input  8  unsigned temperature in whole °C, sampled every rising clk edge.
REQ-007 fan_on  output  1  registered fan enable; 1 = fan running.

Function
REQ-008 Hysteresis controller; states OFF, ARM_ON, ON, ARM_OFF; 2-bit state register plus 16-bit persistence counter.
REQ-009 fan_on SHALL be 1 in ON and ARM_OFF, 0 in OFF and ARM_ON; driven directly from registered state, no combinational path from temperature.
REQ-010 Comparisons unsigned, 8-bit: "hot" = temperature >= ON_THRESHOLD; "cold" = temperature <= OFF_THRESHOLD.
REQ-011 OFF: hot -> ARM_ON with counter = 1; otherwise stay OFF, counter = 0.
REQ-012 ARM_ON: not hot -> OFF, counter = 0; hot and counter == FILTER_CYCLES-1 -> ON, counter = 0; else counter +1.
REQ-013 ON: cold -> ARM_OFF with counter = 1; otherwise stay ON, counter = 0.
REQ-014 ARM_OFF: not cold -> ON, counter = 0; cold and counter == FILTER_CYCLES-1 -> OFF, counter = 0; else counter +1.
REQ-015 If FILTER_CYCLES == 1, OFF goes directly to ON on the first hot sample and ON directly to OFF on the first cold sample (ARM states skipped).
REQ-016 Dead band (OFF_THRESHOLD < temperature < ON_THRESHOLD): fan_on holds its current value indefinitely.
REQ-017 fan_on changes on the rising edge that samples the FILTER_CYCLES-th consecutive qualifying value; one non-qualifying sample restarts the count.
REQ-018 Integrator SHALL guarantee OFF_THRESHOLD < ON_THRESHOLD; behaviour otherwise unspecified.
REQ-019 Unreachable state encodings SHALL recover to OFF on the next clock edge with counter = 0.

Reset
REQ-020 While rst = 1 at a rising edge: state = OFF, counter = 0, fan_on = 0; rst dominates all other inputs.
REQ-021 Reset asserted mid-ARM_ON, ARM_OFF or ON discards any pending count; first post-reset edge evaluates from OFF.

Configuration
REQ-022 Macro FAN_CTRL_FILTER_EN: when defined, persistence filter per REQ-011..REQ-017 with FILTER_CYCLES.
REQ-023 When FAN_CTRL_FILTER_EN is undefined: counter and ARM states omitted; OFF->ON on first hot sample, ON->OFF on first cold sample (1-cycle latency); FILTER_CYCLES ignored.

Verification
REQ-024 rst=1 for 2 cycles, temperature=0 -> fan_on=0, state OFF after release.
REQ-025 Defaults, macro defined: temperature 10 then 19, each held 20000 cycles -> fan_on stays 0.
REQ-026 temperature 20 held -> fan_on rises exactly on the 16th sampling edge at 20; then 18 held -> fan_on stays 1.
REQ-027 From ON, temperature 15 held -> fan_on falls on 16th sampling edge; then 22 -> on again; then 14 -> off again.
REQ-028 Glitch: temperature 20 for 10 cycles, 19 for 1 cycle, 20 for 15 cycles -> fan_on stays 0; one more cycle at 20 -> fan_on = 1.
REQ-029 Macro undefined: temperature 20 -> fan_on = 1 one edge later; 15 -> fan_on = 0 one edge later; rst=1 while ON -> fan_on = 0 next edge.

Source files
------------

// File: rtl/fsm_fan_control.sv
// Hysteresis fan controller with an optional persistence filter on each transition.
// Define FAN_CTRL_FILTER_EN to enable the FILTER_CYCLES filter; otherwise transitions take one edge.
`timescale 1ns/1ps
module fsm_fan_control #(
  parameter logic [7:0]  ON_THRESHOLD  = 8'd20,
  parameter logic [7:0]  OFF_THRESHOLD = 8'd15,
  parameter int unsigned FILTER_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] temperature,
  output logic       fan_on
);

  // Bit 1 of the encoding is the fan enable, so fan_on comes straight off the state flop.
  typedef enum logic [1:0] {
    StOff    = 2'b00,
    StArmOn  = 2'b01,
    StOn     = 2'b10,
    StArmOff = 2'b11
  } state_e;

  state_e state_q, state_d;
  logic   hot, cold;

  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 65535) begin : g_bad_filter
    $error("FILTER_CYCLES must be in 1..65535");
  end

  assign hot    = (temperature >= ON_THRESHOLD);
  assign cold   = (temperature <= OFF_THRESHOLD);
  assign fan_on = state_q[1];

`ifdef FAN_CTRL_FILTER_EN
  localparam logic [15:0] LastCnt     = 16'(FILTER_CYCLES - 1);
  localparam bit          SingleCycle = (FILTER_CYCLES == 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      StOff: begin
        if (hot) begin
          if (SingleCycle) begin
            state_d = StOn;
          end else begin
            state_d = StArmOn;
            cnt_d   = 16'd1;
          end
        end
      end
      StArmOn: begin
        if (!hot) begin
          state_d = StOff;
        end else if (cnt_q == LastCnt) begin
          state_d = StOn;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StOn: begin
        if (cold) begin
          if (SingleCycle) begin
            state_d = StOff;
          end else begin
            state_d = StArmOff;
            cnt_d   = 16'd1;
          end
        end
      end
      StArmOff: begin
        if (!cold) begin
          state_d = StOn;
        end else if (cnt_q == LastCnt) begin
          state_d = StOff;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StOff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StOff;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  // Unfiltered: only StOff and StOn are used; anything else falls back to StOff.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StOff:   if (hot)  state_d = StOn;
      StOn:    if (cold) state_d = StOff;
      default: state_d = StOff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StOff;
    end else begin
      state_q <= state_d;
    end
  end
`endif

endmodule

// File: tb/tb_fsm_fan_control.sv
// Self-checking bench for fsm_fan_control: run-length model checked every cycle plus literal checkpoints.
`timescale 1ns/1ps
module tb_fsm_fan_control;

`ifdef FAN_CTRL_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int F    = 16;
`else
  localparam bit FILT = 1'b0;
  localparam int F    = 1;
`endif
  localparam logic [7:0] ON_T  = 8'd20;
  localparam logic [7:0] OFF_T = 8'd15;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] temperature;
  logic       fan_on;

  int nerr = 0;
  int nchk = 0;
  bit checking = 1'b0;
  int cycle = 0;

  // Model: fan toggles once F consecutive samples qualify for the opposite state.
  bit m_fan = 1'b0;
  int run   = 0;

  fsm_fan_control #(
    .ON_THRESHOLD (ON_T),
    .OFF_THRESHOLD(OFF_T),
    .FILTER_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .temperature(temperature),
    .fan_on     (fan_on)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bit qual;
    cycle++;
    if (rst) begin
      m_fan = 1'b0;
      run   = 0;
    end else begin
      qual = m_fan ? (temperature <= OFF_T) : (temperature >= ON_T);
      run  = qual ? run + 1 : 0;
      if (run == F) begin
        m_fan = !m_fan;
        run   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      nchk++;
      if (fan_on !== m_fan) begin
        nerr++;
        $display("FAIL model cycle=%0d temp=%0d fan_on=%b required=%b",
                 cycle, temperature, fan_on, m_fan);
      end
    end
  end

  task automatic hold(input logic [7:0] t, input int n);
    temperature = t;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input bit exp);
    nchk++;
    if (fan_on !== exp) begin
      nerr++;
      $display("FAIL %s fan_on=%b required=%b", name, fan_on, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    temperature = 8'd0;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    chk("reset", 1'b0);
    rst = 1'b0;

    hold(8'd10, 20000); chk("cold_hold", 1'b0);
    hold(8'd19, 20000); chk("deadband_hold_off", 1'b0);

    hold(8'd20, 15);  chk("on_edge_minus1", FILT ? 1'b0 : 1'b1);
    hold(8'd20, 1);   chk("on_edge", 1'b1);
    hold(8'd18, 100); chk("deadband_hold_on", 1'b1);

    hold(8'd15, 15); chk("off_edge_minus1", FILT ? 1'b1 : 1'b0);
    hold(8'd15, 1);  chk("off_edge", 1'b0);
    hold(8'd22, 16); chk("on_again", 1'b1);
    hold(8'd14, 16); chk("off_again", 1'b0);

    hold(8'd20, 10); chk("glitch_pre", FILT ? 1'b0 : 1'b1);
    hold(8'd19, 1);  chk("glitch_dip", FILT ? 1'b0 : 1'b1);
    hold(8'd20, 15); chk("glitch_post15", FILT ? 1'b0 : 1'b1);
    hold(8'd20, 1);  chk("glitch_post16", 1'b1);

    hold(8'd15, 10); chk("cold_glitch_pre", FILT ? 1'b1 : 1'b0);
    hold(8'd16, 1);  chk("cold_glitch_bump", FILT ? 1'b1 : 1'b0);
    hold(8'd15, 15); chk("cold_glitch_post15", FILT ? 1'b1 : 1'b0);
    hold(8'd15, 1);  chk("cold_glitch_post16", 1'b0);

    // Reset in the middle of an arming run must discard the partial count.
    hold(8'd20, 10);
    rst = 1'b1; hold(8'd20, 1); chk("reset_mid_arm", 1'b0);
    rst = 1'b0;
    hold(8'd20, 15); chk("post_reset_15", FILT ? 1'b0 : 1'b1);
    hold(8'd20, 1);  chk("post_reset_16", 1'b1);

    rst = 1'b1; hold(8'd30, 1); chk("reset_while_on", 1'b0);
    rst = 1'b0;
    hold(8'd30, 1);  chk("first_after_reset", FILT ? 1'b0 : 1'b1);

    hold(8'd255, 16); chk("max_temp_on", 1'b1);
    hold(8'd16, 50);  chk("just_above_off", 1'b1);
    hold(8'd0, 16);   chk("min_temp_off", 1'b0);
    hold(8'd19, 50);  chk("just_below_on", 1'b0);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
